// File: rtl/wave_dma_sched.sv
// wave_dma_sched: 8-channel wave DMA command scheduler, stops before triggers, round robin in each class.
// Optional drop counter is compiled only with WAVE_DMA_SCHED_DROP_CNT_EN defined.
module wave_dma_sched #(
   parameter int GAP = 4
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic [7:0]   req_trig,
   input  logic [7:0]   req_stop,
   input  logic [127:0] req_addr,
   input  logic         dl_busy,
   output logic         O_DMA_TRIG,
   output logic         O_DMA_STOP,
   output logic [2:0]   O_DMA_CHAN,
   output logic [15:0]  O_DMA_ADDR,
   output logic [7:0]   pending,
   output logic         idle,
   output logic [15:0]  drop_cnt
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_ptrig, r_pstop;
   logic [7:0][15:0] r_addr;
   logic [3:0]       r_cnt;
   logic [2:0]       r_ptr, w_sel;
   logic             r_busy;
   logic [7:0]       w_mask, w_clr_trig, w_clr_stop;
   logic             w_found, w_is_stop, w_go, w_issue, w_gap_done;

   // Search starts one past the last served channel; stops shadow triggers.
   always_comb begin
      w_is_stop = |r_pstop;
      w_mask    = w_is_stop ? r_pstop : r_ptrig;
      w_found   = 1'b0;
      w_sel     = r_ptr;
      for (int k = 1; k <= 8; k++) begin
         if (!w_found && w_mask[3'(r_ptr + 3'(k))]) begin
            w_found = 1'b1;
            w_sel   = 3'(r_ptr + 3'(k));
         end
      end
   end

   // r_busy stretches the inhibit one cycle past the falling edge of dl_busy.
   assign w_gap_done = (r_state == S_GAP) && (r_cnt == 4'(GAP - 1));
   assign w_go       = (|w_mask) && !dl_busy && !r_busy;
   assign w_issue    = w_go && ((r_state == S_IDLE) || w_gap_done);
   assign w_clr_trig = (w_issue && !w_is_stop) ? (8'b1 << w_sel) : 8'b0;
   assign w_clr_stop = (w_issue &&  w_is_stop) ? (8'b1 << w_sel) : 8'b0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_issue) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_GAP;
         S_GAP:   if (w_gap_done) w_state_nxt = w_issue ? S_ISSUE : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_ptr      <= 3'd7;
         r_busy     <= 1'b0;
         O_DMA_TRIG <= 1'b0;
         O_DMA_STOP <= 1'b0;
         O_DMA_CHAN <= 3'd0;
         O_DMA_ADDR <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_busy     <= dl_busy;
         r_cnt      <= (r_state == S_GAP) ? r_cnt + 4'd1 : 4'd0;
         O_DMA_TRIG <= w_issue && !w_is_stop;
         O_DMA_STOP <= w_issue &&  w_is_stop;
         if (w_issue) begin
            O_DMA_CHAN <= w_sel;
            r_ptr      <= w_sel;
            if (!w_is_stop) O_DMA_ADDR <= r_addr[w_sel];
         end
      end
   end

   // Clear of the served bit comes first so a same-edge request survives.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_ptrig <= 8'd0;
         r_pstop <= 8'd0;
         r_addr  <= '0;
      end else begin
         r_ptrig <= ((r_ptrig & ~w_clr_trig) | req_trig) & ~req_stop;
         r_pstop <= (r_pstop & ~w_clr_stop) | req_stop;
         for (int n = 0; n < 8; n++)
            if (req_trig[n] && !req_stop[n]) r_addr[n] <= req_addr[16*n +: 16];
      end
   end

   assign pending = r_ptrig | r_pstop;
   assign idle    = (r_state == S_IDLE) && !(|pending);

`ifdef WAVE_DMA_SCHED_DROP_CNT_EN
   logic [15:0] r_drop;
   logic [4:0]  w_drops;
   logic [16:0] w_drop_sum;

   // A trigger being served this edge is not a drop.
   always_comb begin
      w_drops = 5'd0;
      for (int n = 0; n < 8; n++) begin
         if (req_stop[n])
            w_drops = w_drops + 5'(r_ptrig[n] & ~w_clr_trig[n]) + 5'(req_trig[n]);
         else if (req_trig[n])
            w_drops = w_drops + 5'(r_ptrig[n] & ~w_clr_trig[n]);
      end
   end

   assign w_drop_sum = {1'b0, r_drop} + {12'd0, w_drops};

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) r_drop <= 16'd0;
      else       r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
   end

   assign drop_cnt = r_drop;
`else
   assign drop_cnt = 16'd0;
`endif

endmodule

// File: doc/wave_dma_sched.md
WAVE_DMA_SCHED -- requirements
Module: wave_dma_sched

Interface
REQ-001 The block SHALL have parameter GAP, default 4, meaning the number of idle cycles enforced after each issued command (legal range 1..15).
REQ-002 The block SHALL have port clk_sys  input  1  system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port req_trig  input  8  per-channel one-cycle trigger request (bit n = channel n).
REQ-005 The block SHALL have port req_stop  input  8  per-channel one-cycle stop request.
REQ-006 The block SHALL have port req_addr  input  128  per-channel wave start address, channel n in bits [16n+15:16n], sampled with req_trig[n].
REQ-007 The block SHALL have port dl_busy  input  1  wave-ROM download in progress; command issue is inhibited while high.
REQ-008 The block SHALL have port O_DMA_TRIG  output  1  registered one-cycle trigger pulse to the wave_sound DMA.
REQ-009 The block SHALL have port O_DMA_STOP  output  1  registered one-cycle stop pulse to the wave_sound DMA.
REQ-010 The block SHALL have port O_DMA_CHAN  output  3  channel of the current command, held until the next command.
REQ-011 The block SHALL have port O_DMA_ADDR  output  16  start address of the current trigger, held until the next trigger.
REQ-012 The block SHALL have port pending  output  8  OR of pending trigger and pending stop per channel.
REQ-013 The block SHALL have port idle  output  1  high when in IDLE with no pending request.
REQ-014 The block SHALL have port drop_cnt  output  16  count of overwritten or cancelled trigger requests.

Function
REQ-015 Requests SHALL be latched into per-channel pend_trig/pend_stop bits and a per-channel 16-bit address register on the clock edge where the request bit is high.
REQ-016 A req_trig on a channel with pend_trig already set SHALL overwrite the stored address (latest wins) and count as one drop.
REQ-017 A req_stop SHALL set pend_stop and clear pend_trig for that channel; a cleared pend_trig counts as one drop.
REQ-018 req_trig and req_stop on the same channel in the same cycle SHALL result in stop only; the trigger is dropped and counted.
REQ-019 The state machine SHALL have states IDLE, ISSUE, GAP; IDLE->ISSUE when any pend bit is set and dl_busy is low; ISSUE->GAP after one cycle; GAP->IDLE after GAP cycles.
REQ-020 In ISSUE exactly one of O_DMA_TRIG/O_DMA_STOP SHALL be high for exactly one cycle, and the served pend bit SHALL clear on the same edge.
REQ-021 Pending stops SHALL take priority over pending triggers on any channel.
REQ-022 Within a class, selection SHALL be round-robin, searching upward (wrapping 7->0) from the channel after the last served channel; the pointer resets to 7 so channel 0 wins first.
REQ-023 A request asserted in cycle 0 with the block IDLE SHALL produce its output pulse in cycle 2.
REQ-024 A new request for the channel being issued, arriving on the ISSUE edge, SHALL be retained as pending, not lost.
REQ-025 While dl_busy is high no command SHALL be issued; requests continue to latch; a command already in ISSUE or GAP completes.
REQ-026 drop_cnt SHALL saturate at 16'hFFFF; two drops in one cycle SHALL add 2.

Reset
REQ-027 On reset assertion all pend bits, address registers, drop_cnt, O_DMA_CHAN and O_DMA_ADDR SHALL clear to 0, O_DMA_TRIG/O_DMA_STOP to 0, state to IDLE, idle to 1, immediately and asynchronously.
REQ-028 Reset mid-ISSUE SHALL abort the pulse immediately; no command SHALL be issued after reset until a new request.

Configuration
REQ-029 With macro WAVE_DMA_SCHED_DROP_CNT_EN defined, drop_cnt SHALL operate per REQ-016..018, REQ-026; without it, drop_cnt SHALL be tied to 0 and no counter logic compiled.

Verification
REQ-030 req_trig=8'h01, req_addr[15:0]=16'h1234 in cycle 0 -> cycle 2 O_DMA_TRIG=1, O_DMA_CHAN=0, O_DMA_ADDR=16'h1234; idle=1 by cycle 2+GAP+1.
REQ-031 req_trig=8'hFF same cycle, all addresses distinct -> eight triggers on channels 0..7 in order, spaced GAP+1 cycles apart.
REQ-032 req_trig=8'h0C then req_stop=8'h80 next cycle -> order trig ch2, stop ch7, trig ch3.
REQ-033 req_trig and req_stop on ch5 same cycle -> single O_DMA_STOP with chan 5, no trigger, drop_cnt=1 (0 with macro undefined).
REQ-034 dl_busy=1 and req_trig=8'h10 -> no pulse while busy, pending=8'h10; trigger ch4 two cycles after dl_busy falls.
REQ-035 reset asserted during ISSUE with pending=8'h06 -> outputs 0 immediately, pending=0, no pulse after release.
